// File: rtl/stream_vector_player_pkg.sv
// Purpose: shared types for the stream vector player (FSM states, sample type, config check).
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package stream_vector_player_pkg;

    // Playback controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Per-channel sample when DATA_W == 32 (24-bit mantissa, 8-bit exponent float)
    typedef logic [31:0] float_24_8;

    // A pass must hold at least one word and fit in the channel memory
    function automatic logic len_legal(input int unsigned len, input int unsigned depth);
        return (len >= 1) && (len <= depth);
    endfunction

endpackage

// File: rtl/stream_vector_channel.sv
// Purpose: one replay channel: vector memory, read-ahead pointer, pass counter, finished flag.
// Latency: launch at edge T -> memory read of word 0 at T+1 -> valid with word 0 from T+2.
// Backpressure: valid/ready; data, valid, fst and lst hold while valid and not ready.
module stream_vector_channel
    import stream_vector_player_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LOOP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              launch_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [LOOP_W-1:0] loops_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              vld_o,
    output logic              fst_o,
    output logic              lst_o,
    input  logic              rdy_i,
    output logic              fin_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;

    logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_nxt, rd_addr;
    logic [LOOP_W-1:0] pass_q, pass_d, pass_inc;
    logic              fin_q, fin_d;
    logic              vld_q, vld_d;
    logic [1:0]        launch_q, launch_d;
    logic              fire, at_last;

    assign fire     = vld_q & rdy_i;
    assign at_last  = ({1'b0, ptr_q} == (len_i - (ADDR_W+1)'(1)));
    assign ptr_nxt  = at_last ? '0 : ptr_q + ADDR_W'(1);
    assign pass_inc = pass_q + LOOP_W'(1);
    // Read ahead on a fire so the next word is ready the following cycle
    assign rd_addr  = fire ? ptr_nxt : ptr_q;

    // Next-state for pointer, pass count, launch pipe, valid and finished flag
    always_comb begin
        ptr_d    = ptr_q;
        pass_d   = pass_q;
        fin_d    = fin_q;
        vld_d    = vld_q;
        launch_d = {launch_q[0], 1'b0};
        if (clear_i) begin
            ptr_d    = '0;
            pass_d   = '0;
            fin_d    = 1'b0;
            vld_d    = 1'b0;
            launch_d = '0;
        end else if (launch_i) begin
            ptr_d    = '0;
            pass_d   = '0;
            fin_d    = 1'b0;
            vld_d    = 1'b0;
            launch_d = 2'b01;
        end else begin
            if (launch_q[1]) begin
                vld_d = 1'b1;
            end
            if (fire) begin
                ptr_d = ptr_nxt;
                if (at_last) begin
                    // Saturate so an endless run never wraps the count
                    if (pass_q != '1) begin
                        pass_d = pass_inc;
                    end
                    if ((loops_i != '0) && (pass_inc == loops_i)) begin
                        fin_d = 1'b1;
                        vld_d = 1'b0;
                    end
                end
            end
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            pass_q   <= '0;
            fin_q    <= 1'b0;
            vld_q    <= 1'b0;
            launch_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            pass_q   <= pass_d;
            fin_q    <= fin_d;
            vld_q    <= vld_d;
            launch_q <= launch_d;
        end
    end

    // Load port and synchronous read port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        rd_q <= mem[rd_addr];
    end

    // Stall hold comes for free: the read re-fetches ptr_q while not firing
    assign data_o = vld_q ? rd_q : '0;
    assign vld_o  = vld_q;
    assign fst_o  = vld_q & (ptr_q == '0);
    assign lst_o  = vld_q & at_last;
    // Includes a finish happening at this edge so the controller leaves RUN without a bubble
    assign fin_o  = fin_d;

endmodule

// File: rtl/stream_vector_player.sv
// Purpose: multi-channel vector replay source with programmable pass length and loop count.
// Latency: start accepted at edge T -> each channel valid with word 0 from T+2, 1 word/cycle after.
// Backpressure: independent valid/ready per channel; a stalled channel never blocks the others.
module stream_vector_player
    import stream_vector_player_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int NUM_CH = 2,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LOOP_W = 16,
    localparam int WCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WCH_W-1:0]         wr_ch,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [ADDR_W:0]          cfg_len,
    input  logic [LOOP_W-1:0]        cfg_loops,
    input  logic                     start,
    input  logic                     abort,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_vld,
    output logic [NUM_CH-1:0]        out_fst,
    output logic [NUM_CH-1:0]        out_lst,
    input  logic [NUM_CH-1:0]        out_rdy,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q;
    logic [LOOP_W-1:0] loops_q;
    logic              err_q, err_d;
    logic              len_ok, wr_ch_ok, accept, abort_run, wr_go, all_fin;
    logic [NUM_CH-1:0] fin;

    assign len_ok   = len_legal(32'(cfg_len), DEPTH);
    assign wr_ch_ok = (32'(wr_ch) < NUM_CH);
    assign all_fin  = &fin;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: abort beats completion when both land in the same cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (start && len_ok) state_d = ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (all_fin) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and request qualification decoded from the current state
    always_comb begin
        busy      = (state_q == ST_RUN);
        done      = (state_q == ST_DONE);
        accept    = (state_q != ST_RUN) && start && len_ok;
        abort_run = (state_q == ST_RUN) && abort;
        wr_go     = (state_q != ST_RUN) && wr_en && wr_ch_ok;
        err_d     = (start && ((state_q == ST_RUN) || !len_ok)) ||
                    (wr_en && ((state_q == ST_RUN) || !wr_ch_ok));
    end

    // Config latched on an accepted start; error flagged the cycle after the request
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q   <= '0;
            loops_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_d;
            if (accept) begin
                len_q   <= cfg_len;
                loops_q <= cfg_loops;
            end
        end
    end

    assign err = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ch_we;
        assign ch_we = wr_go && (32'(wr_ch) == g);

        stream_vector_channel #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .LOOP_W (LOOP_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .clear_i   (abort_run),
            .launch_i  (accept),
            .len_i     (len_q),
            .loops_i   (loops_q),
            .wr_en_i   (ch_we),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .data_o    (out_data[g*DATA_W +: DATA_W]),
            .vld_o     (out_vld[g]),
            .fst_o     (out_fst[g]),
            .lst_o     (out_lst[g]),
            .rdy_i     (out_rdy[g]),
            .fin_o     (fin[g])
        );
    end

endmodule

// File: tb/tb_stream_vector_player.sv
// Purpose: self-checking bench for stream_vector_player against a word-index replay model.
// Latency: expects first valid two cycles after the accepting edge, then one word per fire.
// Backpressure: drives fixed, alternating and random ready patterns per channel.
module tb_stream_vector_player;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int NUM_CH = 2;
    localparam int ADDR_W = 6;
    localparam int LOOP_W = 16;
    localparam int LIMIT  = 3000;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     wr_en = 1'b0;
    logic [0:0]               wr_ch = '0;
    logic [ADDR_W-1:0]        wr_addr = '0;
    logic [DATA_W-1:0]        wr_data = '0;
    logic [ADDR_W:0]          cfg_len = '0;
    logic [LOOP_W-1:0]        cfg_loops = '0;
    logic                     start = 1'b0;
    logic                     abort = 1'b0;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        out_vld, out_fst, out_lst;
    logic [NUM_CH-1:0]        out_rdy = '0;
    logic                     busy, done, err;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] model [NUM_CH][DEPTH];

    always #5 clk = ~clk;

    stream_vector_player #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .LOOP_W (LOOP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cfg_len   (cfg_len),
        .cfg_loops (cfg_loops),
        .start     (start),
        .abort     (abort),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .out_fst   (out_fst),
        .out_lst   (out_lst),
        .out_rdy   (out_rdy),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input int addr, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_ch   = 1'(ch);
        wr_addr = ADDR_W'(addr);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        model[ch][addr] = d;
    endtask

    // Replays one start; expected word n of a channel is mem[n % len], fst/lst from n % len
    task automatic play(input string nm, input int len, input int loops, input int rdy_mode,
                        input int stop_kind, input int stop_after, input bit inj_err, input bit wr0);
        int idx [NUM_CH];
        int total, cyc, busy_cyc;
        bit err_exp, fin_all, stopped;
        logic [DATA_W-1:0] d;
        total = len * loops;
        foreach (idx[i]) idx[i] = 0;
        if (wr0) begin
            d = $urandom;
            wr_en = 1'b1; wr_ch = 1'b0; wr_addr = '0; wr_data = d;
            model[0][0] = d;
        end
        cfg_len   = (ADDR_W+1)'(len);
        cfg_loops = LOOP_W'(loops);
        start     = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        cyc = 0; busy_cyc = 0; err_exp = 1'b0; stopped = 1'b0;
        while (cyc < LIMIT) begin
            check_val({nm, ":err"}, err, err_exp);
            err_exp = 1'b0;
            fin_all = (loops != 0);
            for (int c = 0; c < NUM_CH; c++) if (idx[c] < total) fin_all = 1'b0;
            if (fin_all) begin
                check_val({nm, ":done_end"}, done, 1);
                check_val({nm, ":busy_end"}, busy, 0);
                check_val({nm, ":vld_end"}, out_vld, 0);
                break;
            end
            check_val({nm, ":busy"}, busy, 1);
            check_val({nm, ":done_run"}, done, 0);
            busy_cyc++;
            for (int c = 0; c < NUM_CH; c++) begin
                bit live, r;
                int w;
                live = (cyc >= 2) && ((loops == 0) || (idx[c] < total));
                case (rdy_mode)
                    0:       r = 1'b1;
                    1:       r = (c == 0) ? 1'b1 : ((cyc % 2) == 0);
                    default: r = 1'($urandom_range(0, 1));
                endcase
                out_rdy[c] = r;
                check_val($sformatf("%s:vld%0d", nm, c), out_vld[c], live);
                if (live && out_vld[c]) begin
                    w = idx[c] % len;
                    check_val($sformatf("%s:data%0d_w%0d", nm, c, idx[c]),
                              out_data[c*DATA_W +: DATA_W], model[c][w]);
                    check_val($sformatf("%s:fst%0d_w%0d", nm, c, idx[c]), out_fst[c], (w == 0));
                    check_val($sformatf("%s:lst%0d_w%0d", nm, c, idx[c]), out_lst[c], (w == len - 1));
                    if (r) idx[c]++;
                end
            end
            if (inj_err) begin
                if (cyc == 5) begin
                    wr_en = 1'b1; wr_ch = 1'b0; wr_addr = '0; wr_data = ~model[0][0];
                    err_exp = 1'b1;
                end
                if (cyc == 6) wr_en = 1'b0;
                if (cyc == 10) begin
                    start = 1'b1;
                    err_exp = 1'b1;
                end
                if (cyc == 11) start = 1'b0;
            end
            if ((stop_kind != 0) && (idx[0] >= stop_after)) begin
                if (stop_kind == 1) abort = 1'b1;
                else reset = 1'b1;
                tick();
                abort = 1'b0;
                reset = 1'b0;
                check_val({nm, ":stop_vld"}, out_vld, 0);
                check_val({nm, ":stop_busy"}, busy, 0);
                check_val({nm, ":stop_done"}, done, 0);
                check_val({nm, ":stop_err"}, err, 0);
                if (stop_kind == 2) begin
                    check_val({nm, ":stop_data"}, out_data, 0);
                    check_val({nm, ":stop_fst"}, out_fst, 0);
                    check_val({nm, ":stop_lst"}, out_lst, 0);
                end
                stopped = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        if (!stopped) begin
            check_val({nm, ":bounded"}, (cyc < LIMIT), 1);
            if ((rdy_mode == 0) && (loops != 0)) begin
                check_val({nm, ":busy_cycles"}, busy_cyc, total + 2);
            end
        end
        out_rdy = '0;
    endtask

    initial begin
        int len, loops;
        reset = 1'b1;
        repeat (3) tick();
        check_val("rst_vld", out_vld, 0);
        check_val("rst_fst", out_fst, 0);
        check_val("rst_lst", out_lst, 0);
        check_val("rst_data", out_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        reset = 1'b0;
        tick();

        for (int a = 0; a < 36; a++) begin
            load(0, a, DATA_W'(a));
            load(1, a, DATA_W'(100 + a));
        end
        for (int a = 36; a < DEPTH; a++) begin
            load(0, a, $urandom);
            load(1, a, $urandom);
        end

        play("basic", 36, 2, 0, 0, 0, 1'b0, 1'b0);
        play("stall", 36, 2, 1, 0, 0, 1'b0, 1'b0);
        play("len1", 1, 3, 0, 0, 0, 1'b0, 1'b0);

        // Illegal starts and abort while DONE leave the state alone
        cfg_len = '0; start = 1'b1; tick(); start = 1'b0;
        check_val("len0_err", err, 1);
        check_val("len0_busy", busy, 0);
        check_val("len0_done", done, 1);
        tick();
        check_val("len0_err_clear", err, 0);
        cfg_len = (ADDR_W+1)'(DEPTH + 1); start = 1'b1; tick(); start = 1'b0;
        check_val("lenbig_err", err, 1);
        check_val("lenbig_done", done, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check_val("idle_abort_done", done, 1);
        check_val("idle_abort_err", err, 0);

        play("abort", 36, 0, 0, 1, 50, 1'b0, 1'b0);
        play("replay", 36, 1, 2, 0, 0, 1'b0, 1'b0);
        play("inject", 36, 2, 2, 0, 0, 1'b1, 1'b0);
        play("wr0", 36, 1, 0, 0, 0, 1'b0, 1'b1);
        play("full", DEPTH, 2, 2, 0, 0, 1'b0, 1'b0);

        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 8; k++) begin
                load(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, DEPTH - 1)), $urandom);
            end
            len   = int'($urandom_range(1, DEPTH));
            loops = int'($urandom_range(1, 3));
            play($sformatf("rand%0d", it), len, loops, 2, 0, 0, 1'b0, 1'b0);
        end

        play("rstmid", 20, 0, 0, 2, 30, 1'b0, 1'b0);
        play("afterrst", 36, 1, 0, 0, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
